// File: rtl/ifmap_load_sched_pkg.sv
// Shared definitions for the ifmap load scheduler: run-FSM encoding and default sizing.
package ifmap_load_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } run_state_t;

  localparam int IMG_PIXELS_DEF = 784;
  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 10;
  localparam int RES_W_DEF      = 4;

endpackage

// File: rtl/ifmap_load_sched.sv
// Streams pixels into the ifmap BRAM and sequences accelerator runs on full banks.
// Define IFMAP_PINGPONG_EN for two banks so loading the next image overlaps the current run.
module ifmap_load_sched
  import ifmap_load_sched_pkg::*;
#(
  parameter int IMG_PIXELS = IMG_PIXELS_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RES_W      = RES_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifmap_wr_in,
  input  logic [DATA_W-1:0] ifmap_din,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_wbank,
  output logic              acc_start,
  output logic              acc_bank,
  input  logic              acc_done,
  input  logic [RES_W-1:0]  acc_result,
  output logic [RES_W-1:0]  result,
  output logic              final_out_valid,
  output logic              busy,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

  run_state_t        r_state, w_state_next;
  logic [ADDR_W-1:0] r_wcnt;
  logic              r_wbank;
  logic              r_rd_ptr;
  logic              r_acc_bank;
  logic [1:0]        r_full;
  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [DATA_W-1:0] r_bram_din;
  logic              r_bram_wbank;
  logic [RES_W-1:0]  r_result;
  logic              r_fov;
  logic              r_overflow;
  logic              w_reading;
  logic              w_accept;
  logic              w_last;
  logic              w_clr;

`ifdef IFMAP_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
  // Only the bank the accelerator is reading is locked; the other keeps filling.
  assign w_reading = ((r_state == S_START) || (r_state == S_RUN)) && (r_acc_bank == r_wbank);
`else
  localparam logic PINGPONG = 1'b0;
  assign w_reading = (r_state != S_IDLE);
`endif

  assign w_accept = ifmap_wr_in && !r_full[r_wbank] && !w_reading;
  assign w_last   = (r_wcnt == LAST_ADDR);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wcnt       <= '0;
      r_wbank      <= 1'b0;
      r_full       <= 2'b00;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_din   <= '0;
      r_bram_wbank <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_bram_we <= w_accept;
      if (w_accept) begin
        r_bram_addr  <= r_wcnt;
        r_bram_din   <= ifmap_din;
        r_bram_wbank <= r_wbank;
        if (w_last) begin
          r_wcnt          <= '0;
          r_full[r_wbank] <= 1'b1;
          r_wbank         <= r_wbank ^ PINGPONG;
        end else begin
          r_wcnt <= r_wcnt + ADDR_W'(1);
        end
      end
      // A bank being read is never the write target, so set and clear never collide.
      if (w_clr) r_full[r_acc_bank] <= 1'b0;
      if (ifmap_wr_in && !w_accept) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc_bank <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_result   <= '0;
      r_fov      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_fov   <= (r_state == S_DONE);
      if ((r_state == S_IDLE) && (w_state_next == S_START)) r_acc_bank <= r_rd_ptr;
      if (w_clr) begin
        r_result <= acc_result;
        r_rd_ptr <= r_rd_ptr ^ PINGPONG;
      end
    end
  end

  // Banks fill alternately from 0, so serving via a toggling read pointer keeps fill order.
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    case (r_state)
      S_IDLE:  if (r_full[r_rd_ptr]) w_state_next = S_START;
      S_START: w_state_next = S_RUN;
      S_RUN: begin
        if (acc_done) begin
          w_clr        = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bram_we         = r_bram_we;
  assign bram_addr       = r_bram_addr;
  assign bram_din        = r_bram_din;
  assign bram_wbank      = r_bram_wbank;
  assign acc_start       = (r_state == S_START);
  assign acc_bank        = r_acc_bank;
  assign busy            = (r_state == S_RUN);
  assign result          = r_result;
  assign final_out_valid = r_fov;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_ifmap_load_sched.sv
// Directed scoreboard bench for ifmap_load_sched; covers the two-bank mode when IFMAP_PINGPONG_EN is defined.
module tb_ifmap_load_sched;

  localparam int N = 784;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ifmap_wr_in = 1'b0;
  logic [7:0] ifmap_din = 8'h00;
  logic       acc_done = 1'b0;
  logic [3:0] acc_result = 4'h0;
  logic       bram_we;
  logic [9:0] bram_addr;
  logic [7:0] bram_din;
  logic       bram_wbank;
  logic       acc_start;
  logic       acc_bank;
  logic [3:0] result;
  logic       final_out_valid;
  logic       busy;
  logic       overflow;

  always #5 clock = ~clock;

  ifmap_load_sched dut (
    .clock(clock), .reset(reset),
    .ifmap_wr_in(ifmap_wr_in), .ifmap_din(ifmap_din),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_wbank(bram_wbank),
    .acc_start(acc_start), .acc_bank(acc_bank),
    .acc_done(acc_done), .acc_result(acc_result),
    .result(result), .final_out_valid(final_out_valid),
    .busy(busy), .overflow(overflow)
  );

  typedef struct packed {
    logic       bank;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_start = 0;
  int   n_fov = 0;
  int   exp_cnt = 0;
  int   start_snap = 0;
  int   exp_fov = 0;
  logic exp_bank = 1'b0;
  logic last_start_bank = 1'b0;
  logic [3:0] exp_res = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample after the edge, log start/valid pulses, score BRAM writes.
  task automatic tick();
    wr_t e;
    @(posedge clock);
    #1;
    if (acc_start === 1'b1) begin
      n_start++;
      last_start_bank = acc_bank;
    end
    if (final_out_valid === 1'b1) n_fov++;
    if (bram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bram_we", {22'b0, bram_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("bram_write", {13'b0, bram_wbank, bram_addr, bram_din}, {13'b0, e});
      end
    end
  endtask

  task automatic pixel(input logic [7:0] d, input bit expect_acc);
    ifmap_wr_in = 1'b1;
    ifmap_din   = d;
    if (expect_acc) begin
      exp_q.push_back({exp_bank, 10'(exp_cnt), d});
      if (exp_cnt == N - 1) begin
        exp_cnt = 0;
`ifdef IFMAP_PINGPONG_EN
        exp_bank = ~exp_bank;
`endif
      end else begin
        exp_cnt++;
      end
    end
    tick();
    ifmap_wr_in = 1'b0;
  endtask

  task automatic load_image(input logic [7:0] xor_mask);
    for (int i = 0; i < N; i++) pixel(8'(i + 1) ^ xor_mask, 1'b1);
  endtask

  task automatic done_pulse(input logic [3:0] r);
    acc_done   = 1'b1;
    acc_result = r;
    tick();
    acc_done = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_bram_we", {31'b0, bram_we}, 32'd0);
    check("rst_bram_addr", {22'b0, bram_addr}, 32'd0);
    check("rst_bram_din", {24'b0, bram_din}, 32'd0);
    check("rst_bram_wbank", {31'b0, bram_wbank}, 32'd0);
    check("rst_acc_start", {31'b0, acc_start}, 32'd0);
    check("rst_acc_bank", {31'b0, acc_bank}, 32'd0);
    check("rst_result", {28'b0, result}, 32'd0);
    check("rst_fov", {31'b0, final_out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    reset = 1'b0;
    $display("[TB] reset released");

    // First image into bank 0
    load_image(8'h00);
    repeat (2) tick();
    $display("[TB] image 1 loaded, starts=%0d", n_start);
    check("img1_start_count", n_start, 32'd1);
    check("img1_start_bank", {31'b0, last_start_bank}, 32'd0);
    check("img1_queue_empty", exp_q.size(), 32'd0);
    check("img1_busy", {31'b0, busy}, 32'd1);
    check("img1_overflow", {31'b0, overflow}, 32'd0);

`ifdef IFMAP_PINGPONG_EN
    // Second image streams into bank 1 while bank 0 is being processed
    load_image(8'h5A);
    $display("[TB] image 2 streamed during run");
    check("pp_overflow", {31'b0, overflow}, 32'd0);
    check("pp_queue_empty", exp_q.size(), 32'd0);
    check("pp_start_count", n_start, 32'd1);
    check("pp_busy", {31'b0, busy}, 32'd1);
`else
    // Single bank: pixel during RUN is dropped and sets overflow
    pixel(8'hAA, 1'b0);
    $display("[TB] pixel during run, overflow=%0b", overflow);
    check("sb_overflow_set", {31'b0, overflow}, 32'd1);
    repeat (97) tick();
    check("sb_busy_hold", {31'b0, busy}, 32'd1);
`endif

    done_pulse(4'd7);
    exp_res = 4'd7;
    exp_fov++;
    $display("[TB] acc_done result=7");
    check("done1_result", {28'b0, result}, 32'd7);
    check("done1_fov_early", {31'b0, final_out_valid}, 32'd0);
    check("done1_busy", {31'b0, busy}, 32'd0);
    tick();
    check("done1_fov", {31'b0, final_out_valid}, 32'd1);

`ifdef IFMAP_PINGPONG_EN
    tick();
    check("pp_start2_pulse", {31'b0, acc_start}, 32'd1);
    check("pp_start2_bank", {31'b0, acc_bank}, 32'd1);
    check("pp_start2_count", n_start, 32'd2);
    tick();
    done_pulse(4'd3);
    exp_res = 4'd3;
    exp_fov++;
    $display("[TB] second image done result=3");
    check("pp_done2_result", {28'b0, result}, 32'd3);
    tick();
    check("pp_done2_fov", {31'b0, final_out_valid}, 32'd1);
    tick();
`else
    tick();
    check("sb_fov_one_cycle", {31'b0, final_out_valid}, 32'd0);
    check("sb_overflow_sticky", {31'b0, overflow}, 32'd1);
`endif

    // acc_done while idle must be ignored
    done_pulse(4'd5);
    repeat (3) tick();
    $display("[TB] stray acc_done in idle");
    check("idle_done_result", {28'b0, result}, {28'b0, exp_res});
    check("idle_done_fov", n_fov, exp_fov);

    // Reset in the middle of a load abandons the partial image
    for (int i = 0; i < 400; i++) pixel(8'(i + 1), 1'b1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    exp_cnt  = 0;
    exp_bank = 1'b0;
    start_snap = n_start;
    $display("[TB] reset after 400 pixels");
    check("midrst_queue_empty", exp_q.size(), 32'd0);
    check("midrst_bram_addr", {22'b0, bram_addr}, 32'd0);
    check("midrst_overflow", {31'b0, overflow}, 32'd0);
    check("midrst_result", {28'b0, result}, 32'd0);
    repeat (10) tick();
    check("midrst_no_start", n_start, start_snap);

    load_image(8'h00);
    repeat (2) tick();
    $display("[TB] fresh image after reset loaded");
    check("fresh_start_count", n_start, start_snap + 1);
    check("fresh_start_bank", {31'b0, last_start_bank}, 32'd0);
    repeat (50) tick();
    done_pulse(4'd9);
    check("fresh_result", {28'b0, result}, 32'd9);
    tick();
    check("fresh_fov", {31'b0, final_out_valid}, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
